// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receive core: oversampled start detect, centre sampling, parity/stop check
//
// Ports:
//   clk        oversampling clock
//   rst        asynchronous, active-low reset
//   rx_in      serial line, idle high, asynchronous to clk
//   prescale   oversampling ratio (8, 16 or 32; 0 is treated as 8)
//   par_en     1 = parity bit follows the data bits
//   par_typ    0 = even parity, 1 = odd parity
//   p_data     last correctly received word
//   data_valid one-cycle pulse, p_data updated with a good frame
//   par_err    one-cycle pulse, parity mismatch in the frame just ended
//   stp_err    one-cycle pulse, stop bit sampled low
//
// Build option:
//   RX_MAJORITY_VOTE_EN  defined: each bit is the majority of three samples
//                        around the bit centre; undefined: single centre sample.

module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BC_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic                  rx_m;
    logic                  rx_s;
    logic [PRESC_W-1:0]    presc_l;
    logic [PRESC_W-1:0]    presc_eff;
    logic [PRESC_W-1:0]    half;
    logic [PRESC_W-1:0]    last;
    logic                  par_en_l;
    logic                  par_typ_l;
    logic [PRESC_W-1:0]    edge_cnt;
    logic [BC_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_acc;
    logic                  perr;
    logic                  serr;
    logic                  samp_bit;
    logic                  bit_end;
    logic                  frame_done;

    // Two-flop synchronizer; loaded with 1s so reset looks like an idle line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end

    assign presc_eff  = (prescale == '0) ? PRESC_W'(8) : prescale;
    assign half       = presc_l >> 1;
    assign last       = presc_l - PRESC_W'(1);
    assign bit_end    = (edge_cnt == last);
    assign frame_done = (state == STOP) && bit_end;
    assign serr       = ~samp_bit;

    // The sampled bit is held in samp_bit and consumed at bit_end, so both
    // builds act on the bit at the same edge and frame timing is identical.
`ifdef RX_MAJORITY_VOTE_EN
    logic vote_a;
    logic vote_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vote_a   <= 1'b1;
            vote_b   <= 1'b1;
            samp_bit <= 1'b1;
        end else if (state != IDLE) begin
            if (edge_cnt == half - PRESC_W'(1)) begin
                vote_a <= rx_s;
            end
            if (edge_cnt == half) begin
                vote_b <= rx_s;
            end
            if (edge_cnt == half + PRESC_W'(1)) begin
                samp_bit <= (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_bit <= 1'b1;
        end else if ((state != IDLE) && (edge_cnt == half)) begin
            samp_bit <= rx_s;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                // A start bit that is high at its centre was a glitch.
                if (bit_end) begin
                    state_next = samp_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt == BC_W'(DATA_WIDTH - 1))) begin
                    state_next = par_en_l ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_l    <= PRESC_W'(8);
            par_en_l   <= 1'b0;
            par_typ_l  <= 1'b0;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            perr       <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if (state == IDLE) begin
                edge_cnt <= '0;
                // Frame configuration is frozen at the start edge.
                if (!rx_s) begin
                    bit_cnt   <= '0;
                    presc_l   <= presc_eff;
                    par_en_l  <= par_en;
                    par_typ_l <= par_typ;
                    par_acc   <= 1'b0;
                    perr      <= 1'b0;
                end
            end else begin
                edge_cnt <= bit_end ? '0 : edge_cnt + PRESC_W'(1);
            end

            // Right shift: first (LSB) bit ends up at bit 0 after a full word.
            if ((state == DATA) && bit_end) begin
                shreg   <= {samp_bit, shreg[DATA_WIDTH-1:1]};
                par_acc <= par_acc ^ samp_bit;
                bit_cnt <= bit_cnt + BC_W'(1);
            end

            if ((state == PARITY) && bit_end) begin
                perr <= (samp_bit != (par_acc ^ par_typ_l));
            end

            if (frame_done) begin
                if (!perr && !serr) begin
                    p_data     <= shreg;
                    data_valid <= 1'b1;
                end else begin
                    par_err <= perr;
                    stp_err <= serr;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx

module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd16;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // flags = {data_valid, par_err, stp_err}; data = required p_data; due = cycle or 0
    typedef struct {
        logic [2:0] flags;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic expect_evt(input logic [2:0] f, input logic [7:0] d, input int due);
        exp_t e;
        e.flags = f;
        e.data  = d;
        e.due   = due;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (data_valid || par_err || stp_err) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {data_valid, par_err, stp_err}, 0);
            end else begin
                mon_e = sb.pop_front();
                check("flags", {data_valid, par_err, stp_err}, mon_e.flags);
                check("p_data", p_data, mon_e.data);
                if (mon_e.due != 0) check("latency", cyc, mon_e.due);
            end
        end
    end

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic drive_bit(input logic b, input int presc);
        rx_in = b;
        repeat (presc) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int presc, input logic has_par,
                              input logic pbit, input logic stop);
        drive_bit(1'b0, presc);
        for (int i = 0; i < 8; i++) drive_bit(d[i], presc);
        if (has_par) drive_bit(pbit, presc);
        drive_bit(stop, presc);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_p_data"}, p_data, 0);
        check({tag, "_data_valid"}, data_valid, 0);
        check({tag, "_par_err"}, par_err, 0);
        check({tag, "_stp_err"}, stp_err, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b1;
        idle(4);

        // 0xA5, prescale 8, no parity: latency 3 + 10*8 = 83 cycles
        prescale = 6'd8; par_en = 1'b0;
        expect_evt(3'b100, 8'hA5, cyc + 83);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        idle(10);

        // even parity on 0x3C: good bit is 0
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
        expect_evt(3'b100, 8'h3C, 0);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1);
        idle(10);
        expect_evt(3'b010, 8'h3C, 0);
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1);
        idle(10);

        // parity and stop errors together
        prescale = 6'd8;
        expect_evt(3'b011, 8'h3C, 0);
        send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b0);
        idle(10);

        // stop error, then a clean frame
        par_en = 1'b0;
        expect_evt(3'b001, 8'h3C, 0);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0);
        idle(10);
        expect_evt(3'b100, 8'h0F, 0);
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1);
        idle(10);

        // start-bit glitch of 3 cycles, then 0x81
        prescale = 6'd16;
        rx_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(40);
        expect_evt(3'b100, 8'h81, 0);
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1);
        idle(10);

        // odd parity, back-to-back frames, prescale changed mid-frame
        prescale = 6'd32; par_en = 1'b1; par_typ = 1'b1;
        expect_evt(3'b100, 8'h01, 0);
        expect_evt(3'b100, 8'hFF, 0);
        fork
            begin
                send_frame(8'h01, 32, 1'b1, 1'b0, 1'b1);
                send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b1);
            end
            begin
                repeat (100) @(posedge clk);
                prescale = 6'd8;
                repeat (100) @(posedge clk);
                prescale = 6'd32;
                repeat (300) @(posedge clk);
                prescale = 6'd8;
            end
        join
        idle(10);

        // prescale 0 behaves as 8
        prescale = 6'd0; par_en = 1'b0;
        expect_evt(3'b100, 8'h5A, 0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        idle(10);

        // reset mid-DATA of 0x77, then 0x99
        prescale = 6'd8;
        fork
            send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1);
            begin
                repeat (30) @(posedge clk);
                #2;
                rst = 1'b0;
                #1;
                check_outputs_zero("midreset");
            end
        join
        idle(2);
        rst = 1'b1;
        idle(10);
        expect_evt(3'b100, 8'h99, 0);
        send_frame(8'h99, 8, 1'b0, 1'b0, 1'b1);
        idle(10);

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
